// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : State encoding and field widths shared by the match controller.
// Revision : 1.0
// ============================================================================
package pong_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 4;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [SCORE_W-1:0] score_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_RALLY = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_ctrl_if
// Brief    : Control/status bundle between the match controller and the
//            pong datapath. pause_btn exists only with PONG_PAUSE_EN.
// Revision : 1.0
// ============================================================================
interface pong_match_ctrl_if
  import pong_pkg::*;
  ;

  logic   frame_tick;
  logic   start_btn;
`ifdef PONG_PAUSE_EN
  logic   pause_btn;
`endif
  logic   point_l;
  logic   point_r;
  logic   ball_run;
  logic   speed_fast;
  score_t score_l;
  score_t score_r;
  logic   game_over;
  logic   winner;
  state_t state_o;

  modport master (
`ifdef PONG_PAUSE_EN
    output pause_btn,
`endif
    output frame_tick,
    output start_btn,
    output point_l,
    output point_r,
    input  ball_run,
    input  speed_fast,
    input  score_l,
    input  score_r,
    input  game_over,
    input  winner,
    input  state_o
  );

  modport slave (
`ifdef PONG_PAUSE_EN
    input  pause_btn,
`endif
    input  frame_tick,
    input  start_btn,
    input  point_l,
    input  point_r,
    output ball_run,
    output speed_fast,
    output score_l,
    output score_r,
    output game_over,
    output winner,
    output state_o
  );

endinterface : pong_match_ctrl_if
`default_nettype wire

// File: rtl/pong_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : pong_edge_det
// Brief    : Rising-edge detector; one-cycle pulse per low-to-high level change.
// Revision : 1.0
// ============================================================================
module pong_edge_det (
  input  wire  clk,
  input  wire  rst_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_pulse = i_level & ~r_prev;

endmodule : pong_edge_det
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_ctrl
// Brief    : Match sequencer: state machine, authoritative scores, serve and
//            speed timing. Macro PONG_PAUSE_EN adds pause_btn and state PAUSE.
// Revision : 1.0
// ============================================================================
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int FAST_FRAMES  = 600,
  parameter int CNT_W        = 10
) (
  input  wire               vga_clk,
  input  wire               sys_rst_n,
  pong_match_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   c_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   c_FAST       = CNT_W'(FAST_FRAMES);
  localparam logic [SCORE_W-1:0] c_WIN        = SCORE_W'(WIN_SCORE);

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  score_t             r_score_l;
  score_t             r_score_r;
  logic               r_winner;
  logic               r_ball_run;
  logic               r_speed_fast;
  logic               r_game_over;

  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  score_t             w_score_l_nxt;
  score_t             w_score_r_nxt;
  score_t             w_score_l_inc;
  score_t             w_score_r_inc;
  logic               w_winner_nxt;
  logic               w_speed_nxt;
  logic               w_start_edge;

  pong_edge_det u_start_edge (
    .clk     (vga_clk),
    .rst_n   (sys_rst_n),
    .i_level (bus.start_btn),
    .o_pulse (w_start_edge)
  );

`ifdef PONG_PAUSE_EN
  logic w_pause_edge;

  pong_edge_det u_pause_edge (
    .clk     (vga_clk),
    .rst_n   (sys_rst_n),
    .i_level (bus.pause_btn),
    .o_pulse (w_pause_edge)
  );
`endif

  assign w_score_l_inc = r_score_l + SCORE_W'(1);
  assign w_score_r_inc = r_score_r + SCORE_W'(1);

  // Any state change clears or holds the counter, so a coincident frame_tick
  // is never counted by the new state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_winner_nxt  = r_winner;

    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt   = ST_SERVE;
          w_cnt_nxt     = '0;
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
        end
      end

      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (r_cnt == c_SERVE_LAST) begin
            w_state_nxt = ST_RALLY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_RALLY: begin
        // Left point takes priority; a simultaneous right point is dropped.
        if (bus.point_l) begin
          w_score_l_nxt = w_score_l_inc;
          w_cnt_nxt     = '0;
          if (w_score_l_inc == c_WIN) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_SERVE;
          end
        end else if (bus.point_r) begin
          w_score_r_nxt = w_score_r_inc;
          w_cnt_nxt     = '0;
          if (w_score_r_inc == c_WIN) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SERVE;
          end
`ifdef PONG_PAUSE_EN
        end else if (w_pause_edge) begin
          w_state_nxt = ST_PAUSE;
`endif
        end else if (bus.frame_tick && (r_cnt != c_FAST)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        if (w_pause_edge) begin
          w_state_nxt = ST_RALLY;
        end
      end
`endif

      ST_OVER: begin
        if (w_start_edge) begin
          w_state_nxt   = ST_SERVE;
          w_cnt_nxt     = '0;
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
          w_winner_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Speed is held through PAUSE and recomputed from the counter in RALLY.
  always_comb begin
    w_speed_nxt = 1'b0;
    if (w_state_nxt == ST_RALLY) begin
      w_speed_nxt = (w_cnt_nxt == c_FAST);
    end else if (w_state_nxt == ST_PAUSE) begin
      w_speed_nxt = r_speed_fast;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_winner     <= 1'b0;
      r_ball_run   <= 1'b0;
      r_speed_fast <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_score_l    <= w_score_l_nxt;
      r_score_r    <= w_score_r_nxt;
      r_winner     <= w_winner_nxt;
      r_ball_run   <= (w_state_nxt == ST_RALLY);
      r_speed_fast <= w_speed_nxt;
      r_game_over  <= (w_state_nxt == ST_OVER);
    end
  end

  assign bus.ball_run   = r_ball_run;
  assign bus.speed_fast = r_speed_fast;
  assign bus.score_l    = r_score_l;
  assign bus.score_r    = r_score_r;
  assign bus.game_over  = r_game_over;
  assign bus.winner     = r_winner;
  assign bus.state_o    = r_state;

endmodule : pong_match_ctrl
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_match_ctrl
// Brief    : Directed self-checking bench for pong_match_ctrl
//            (WIN_SCORE=3, SERVE_FRAMES=4, FAST_FRAMES=8).
// Revision : 1.0
// ============================================================================
module tb_pong_match_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_RALLY = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (4),
    .FAST_FRAMES  (8),
    .CNT_W        (4)
  ) u_dut (
    .vga_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       tick;
    logic       start;
    logic       pl;
    logic       pr;
    logic [2:0] st;
    logic       br;
    logic       sf;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
    logic       win;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(int n, logic tick, logic start, logic pl, logic pr,
                               logic [2:0] st, logic br, logic sf,
                               logic [3:0] sl, logic [3:0] sr, logic go, logic win);
    vec_t v;
    v.n = n; v.tick = tick; v.start = start; v.pl = pl; v.pr = pr;
    v.st = st; v.br = br; v.sf = sf; v.sl = sl; v.sr = sr; v.go = go; v.win = win;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic br,
                         input logic sf, input logic [3:0] sl, input logic [3:0] sr,
                         input logic go, input logic win);
    chk({tag, ".state"},      32'(bus.state_o),    32'(st));
    chk({tag, ".ball_run"},   32'(bus.ball_run),   32'(br));
    chk({tag, ".speed_fast"}, 32'(bus.speed_fast), 32'(sf));
    chk({tag, ".score_l"},    32'(bus.score_l),    32'(sl));
    chk({tag, ".score_r"},    32'(bus.score_r),    32'(sr));
    chk({tag, ".game_over"},  32'(bus.game_over),  32'(go));
    chk({tag, ".winner"},     32'(bus.winner),     32'(win));
  endtask

  task automatic cyc(input logic tick, input logic start, input logic pl, input logic pr);
    bus.frame_tick = tick;
    bus.start_btn  = start;
    bus.point_l    = pl;
    bus.point_r    = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.point_l    = 1'b0;
    bus.point_r    = 1'b0;
`ifdef PONG_PAUSE_EN
    bus.pause_btn  = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         trans;
    logic [2:0] prev;
    n_checks = 0;
    n_errors = 0;

    // Full match: serve timing, speed-up, dropped right point, win, held start.
    vt.push_back(mkv(1, 0, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 1, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(2, 1, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 1, 0, 0, 0, S_RALLY, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(7, 1, 0, 0, 0, S_RALLY, 1, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 1, 0, 0, 0, S_RALLY, 1, 1, 0, 0, 0, 0));
    vt.push_back(mkv(3, 1, 0, 0, 0, S_RALLY, 1, 1, 0, 0, 0, 0));
    vt.push_back(mkv(1, 1, 0, 1, 0, S_SERVE, 0, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 0, 0, 0, 1, S_SERVE, 0, 0, 1, 0, 0, 0));
    vt.push_back(mkv(3, 1, 0, 0, 0, S_SERVE, 0, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 1, 0, 0, 0, S_RALLY, 1, 0, 1, 0, 0, 0));
    vt.push_back(mkv(1, 0, 0, 1, 1, S_SERVE, 0, 0, 2, 0, 0, 0));
    vt.push_back(mkv(4, 1, 0, 0, 0, S_RALLY, 1, 0, 2, 0, 0, 0));
    vt.push_back(mkv(1, 0, 0, 0, 1, S_SERVE, 0, 0, 2, 1, 0, 0));
    vt.push_back(mkv(4, 1, 0, 0, 0, S_RALLY, 1, 0, 2, 1, 0, 0));
    vt.push_back(mkv(1, 0, 0, 0, 1, S_SERVE, 0, 0, 2, 2, 0, 0));
    vt.push_back(mkv(4, 1, 0, 0, 0, S_RALLY, 1, 0, 2, 2, 0, 0));
    vt.push_back(mkv(1, 1, 1, 0, 1, S_OVER,  0, 0, 2, 3, 1, 1));
    vt.push_back(mkv(1, 0, 1, 0, 1, S_OVER,  0, 0, 2, 3, 1, 1));
    vt.push_back(mkv(3, 1, 1, 0, 0, S_OVER,  0, 0, 2, 3, 1, 1));
    vt.push_back(mkv(1, 0, 0, 0, 0, S_OVER,  0, 0, 2, 3, 1, 1));
    vt.push_back(mkv(1, 0, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 1, 1, 0, S_SERVE, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkv(1, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0));

    do_reset();
    chk_all("reset", S_IDLE, 0, 0, 0, 0, 0, 0);

    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) cyc(vt[i].tick, vt[i].start, vt[i].pl, vt[i].pr);
      chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].br, vt[i].sf,
              vt[i].sl, vt[i].sr, vt[i].go, vt[i].win);
    end

    // Held start in IDLE yields exactly one transition.
    do_reset();
    trans = 0;
    prev  = bus.state_o;
    for (int k = 0; k < 100; k++) begin
      cyc(0, 1, 0, 0);
      if (bus.state_o !== prev) trans++;
      prev = bus.state_o;
    end
    chk("held_start.transitions", 32'(trans), 32'd1);
    chk("held_start.state", 32'(bus.state_o), 32'(S_SERVE));
    cyc(0, 0, 0, 0);

    // Asynchronous reset in the middle of a fast rally with a nonzero score.
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (4) cyc(1, 0, 0, 0);
    repeat (8) cyc(1, 0, 0, 0);
    chk_all("pre_async_rst", S_RALLY, 1, 1, 1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", S_IDLE, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk_all("post_rst", S_IDLE, 0, 0, 0, 0, 0, 0);

`ifdef PONG_PAUSE_EN
    // Pause at counter 5 holds the counter; resume needs 3 more ticks to go fast.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    chk_all("pre_pause", S_RALLY, 1, 0, 0, 0, 0, 0);
    bus.pause_btn = 1'b1;
    cyc(1, 0, 0, 0);
    chk_all("pause_enter", S_PAUSE, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    chk_all("pause_ignores", S_PAUSE, 0, 0, 0, 0, 0, 0);
    bus.pause_btn = 1'b0;
    repeat (4) cyc(1, 0, 0, 0);
    chk_all("pause_hold", S_PAUSE, 0, 0, 0, 0, 0, 0);
    bus.pause_btn = 1'b1;
    cyc(0, 0, 0, 0);
    chk_all("pause_exit", S_RALLY, 1, 0, 0, 0, 0, 0);
    bus.pause_btn = 1'b0;
    repeat (2) cyc(1, 0, 0, 0);
    chk_all("resume_cnt7", S_RALLY, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk_all("resume_cnt8", S_RALLY, 1, 1, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pong_match_ctrl
`default_nettype wire
